// File: rtl/axi_read_arbiter_if.sv
// Bus bundle for axi_read_arbiter: requester-side AR/R signals and the
// shared AXI read master port. "slave" is the arbiter's view; "master" is
// the view of whatever surrounds it (the clients plus the read bridge).
interface axi_read_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 64
);
  // Requester side
  logic [NREQ-1:0]    req_arvalid;
  logic [NREQ*AW-1:0] req_araddr;
  logic [NREQ*8-1:0]  req_arlen;
  logic [NREQ*3-1:0]  req_arsize;
  logic [NREQ*2-1:0]  req_arburst;
  logic [NREQ-1:0]    req_arready;
  logic [NREQ-1:0]    req_rvalid;
  logic [NREQ-1:0]    req_rready;
  logic [DW-1:0]      req_rdata;
  logic [1:0]         req_rresp;
  logic               req_rlast;

  // Shared AXI read master port
  logic [AW-1:0]      m_axi_araddr;
  logic [7:0]         m_axi_arlen;
  logic [2:0]         m_axi_arsize;
  logic [1:0]         m_axi_arburst;
  logic               m_axi_arvalid;
  logic               m_axi_arready;
  logic [DW-1:0]      m_axi_rdata;
  logic [1:0]         m_axi_rresp;
  logic               m_axi_rlast;
  logic               m_axi_rvalid;
  logic               m_axi_rready;

  modport slave (
    input  req_arvalid, req_araddr, req_arlen, req_arsize, req_arburst,
    output req_arready, req_rvalid,
    input  req_rready,
    output req_rdata, req_rresp, req_rlast,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport master (
    output req_arvalid, req_araddr, req_arlen, req_arsize, req_arburst,
    input  req_arready, req_rvalid,
    output req_rready,
    input  req_rdata, req_rresp, req_rlast,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin sharing of one AXI read master port among
// NREQ requesters, one burst at a time. R beats are steered combinationally
// to the requester that owns the burst until the beat carrying rlast.
// Optional macro AXI_RD_ARB_BEATCHK_EN adds a beat counter that flags
// rlast arriving early or late on the sticky err_rlast output.
module axi_read_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 64
) (
  input  logic                      clk,
  input  logic                      resetn,
  axi_read_arbiter_if.slave         bus,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      err_rlast
);
  localparam int IW = $clog2(NREQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [AW-1:0] ar_addr;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic [1:0]    ar_burst;

  logic [AW-1:0] addr_arr  [NREQ];
  logic [7:0]    len_arr   [NREQ];
  logic [2:0]    size_arr  [NREQ];
  logic [1:0]    burst_arr [NREQ];

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   cand_sum;
  logic [IW-1:0] cand;
  logic [IW-1:0] next_ptr;
  logic          r_beat;

  // Unpack the requester payload buses into per-requester arrays
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.req_araddr[gi*AW +: AW];
    assign len_arr[gi]   = bus.req_arlen[gi*8 +: 8];
    assign size_arr[gi]  = bus.req_arsize[gi*3 +: 3];
    assign burst_arr[gi] = bus.req_arburst[gi*2 +: 2];
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand_sum >= (IW+1)'(NREQ)) cand_sum = cand_sum - (IW+1)'(NREQ);
      cand = cand_sum[IW-1:0];
      if (!pick_found && bus.req_arvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Accept pulse to the winner while idle; held low throughout reset
  always_comb begin
    bus.req_arready = '0;
    if (resetn && (state == IDLE) && pick_found) bus.req_arready[pick_idx] = 1'b1;
  end

  // R steering: only the owner of the burst sees rvalid and drives rready
  always_comb begin
    bus.m_axi_rready = 1'b0;
    bus.req_rvalid   = '0;
    if (state == DATA) begin
      bus.m_axi_rready         = bus.req_rready[grant_id];
      bus.req_rvalid[grant_id] = bus.m_axi_rvalid;
    end
  end

  assign r_beat   = (state == DATA) && bus.m_axi_rvalid && bus.m_axi_rready;
  assign next_ptr = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

  // Burst sequencer: grant and latch payload, hold AR, then route R until rlast
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            ar_addr  <= addr_arr[pick_idx];
            ar_len   <= len_arr[pick_idx];
            ar_size  <= size_arr[pick_idx];
            ar_burst <= burst_arr[pick_idx];
            grant_id <= pick_idx;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (bus.m_axi_arready) state <= DATA;
        end
        DATA: begin
          if (r_beat && bus.m_axi_rlast) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_axi_araddr  = ar_addr;
  assign bus.m_axi_arlen   = ar_len;
  assign bus.m_axi_arsize  = ar_size;
  assign bus.m_axi_arburst = ar_burst;
  assign bus.m_axi_arvalid = (state == ADDR);

  assign bus.req_rdata = bus.m_axi_rdata;
  assign bus.req_rresp = bus.m_axi_rresp;
  assign bus.req_rlast = bus.m_axi_rlast;

  assign busy = (state != IDLE);

`ifdef AXI_RD_ARB_BEATCHK_EN
  logic [7:0] beat_cnt;
  logic       err_q;

  // Beats remaining after the current one; rlast must coincide with zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else if ((state == ADDR) && bus.m_axi_arready) begin
      beat_cnt <= ar_len;
    end else if (r_beat) begin
      if (bus.m_axi_rlast ? (beat_cnt != 8'd0) : (beat_cnt == 8'd0)) err_q <= 1'b1;
      if (!bus.m_axi_rlast && (beat_cnt != 8'd0)) beat_cnt <= beat_cnt - 8'd1;
    end
  end

  assign err_rlast = err_q;
`else
  assign err_rlast = 1'b0;
`endif

endmodule
